// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit_pkg
//  Purpose  : Shared defines for the fetch stage. Holds the next-PC selector
//             codes, the fetch FSM state encodings and the default addresses.
//  Revision : 1.0  initial release
// ============================================================================
package pc_fetch_unit_pkg;

  // Next-PC source selectors used by the ID-stage next-PC mux
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  // Fetch FSM state encodings
  typedef enum logic [0:0] {
    PCU_RUN     = 1'b0,
    PCU_HANDLER = 1'b1
  } pcu_state_t;

  // Default addresses and the fetch-side exception code
  localparam logic [31:0] C_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] C_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] C_IM_LO      = 32'h0000_3000;
  localparam logic [31:0] C_IM_HI      = 32'h0000_6FFF;
  localparam logic [4:0]  C_EXC_ADEL   = 5'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_addr_check.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_addr_check
//  Purpose  : Combinational alignment/range checker. Flags an address that is
//             not word aligned or lies outside [LO, HI]. The same block serves
//             data-side AdEL/AdES by passing a different code and window.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_addr_check #(
  parameter logic [31:0] LO       = 32'h0000_3000,
  parameter logic [31:0] HI       = 32'h0000_6FFF,
  parameter logic [4:0]  EXC_CODE = 5'd4
) (
  input  logic [31:0] addr,
  output logic        exc_valid,
  output logic [4:0]  exc_code
);

  logic w_misaligned;
  logic w_out_of_range;

  // Unsigned 32-bit comparisons; the code is zero whenever no fault is present
  always_comb begin
    w_misaligned   = (addr[1:0] != 2'b00);
    w_out_of_range = (addr < LO) || (addr > HI);
    exc_valid      = w_misaligned || w_out_of_range;
    exc_code       = exc_valid ? EXC_CODE : 5'd0;
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit
//  Purpose  : F-stage PC register with redirect selection (reset, exception
//             entry, eret, stall, normal advance), fetch AdEL flagging,
//             delay-slot flag, handler-mode FSM and a retired-fetch counter.
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = C_RESET_PC,
  parameter logic [31:0] HANDLER_PC = C_HANDLER_PC,
  parameter logic [31:0] IM_LO      = C_IM_LO,
  parameter logic [31:0] IM_HI      = C_IM_HI,
  parameter logic [4:0]  EXC_ADEL   = C_EXC_ADEL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] nextPC,
  input  logic        jump_D,
  input  logic        eret_D,
  input  logic [31:0] EPC,
  input  logic        req,
  output logic [31:0] PC_F,
  output logic        kill_F,
  output logic        excValid_F,
  output logic [4:0]  ExcCode_F,
  output logic        BD_F,
  output logic        in_handler,
  output logic [31:0] fetch_count
);

  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  pcu_state_t  r_state;

  pcu_state_t  w_state_next;
  logic [31:0] w_pc_next;
  logic        w_count_en;

  fetch_addr_check #(
    .LO       (IM_LO),
    .HI       (IM_HI),
    .EXC_CODE (EXC_ADEL)
  ) u_fetch_addr_check (
    .addr      (r_pc),
    .exc_valid (excValid_F),
    .exc_code  (ExcCode_F)
  );

  // Redirect priority req > eret > stall > advance; req and eret both beat a stall
  always_comb begin
    w_pc_next = nextPC;
    if (req) begin
      w_pc_next = HANDLER_PC;
    end else if (eret_D) begin
      w_pc_next = EPC;
    end else if (stall) begin
      w_pc_next = r_pc;
    end
  end

  // FSM next state: req always lands in HANDLER (no nesting); eret leaves it only without req
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PCU_RUN: begin
        if (req) begin
          w_state_next = PCU_HANDLER;
        end
      end
      PCU_HANDLER: begin
        if (!req && eret_D) begin
          w_state_next = PCU_RUN;
        end
      end
      default: w_state_next = PCU_RUN;
    endcase
  end

  // Squash the F instruction on its own fetch fault or on an eret redirect (no delay slot)
  always_comb begin
    kill_F     = excValid_F | eret_D;
    BD_F       = jump_D;
    in_handler = (r_state == PCU_HANDLER);
    w_count_en = !stall && !req && !kill_F;
  end

  // PC register, FSM state and retired-fetch counter; reset discards any same-cycle redirect
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_state       <= PCU_RUN;
      r_fetch_count <= 32'd0;
    end else begin
      r_pc    <= w_pc_next;
      r_state <= w_state_next;
      if (w_count_en) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign PC_F        = r_pc;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_unit
//  Purpose  : Directed self-checking bench for pc_fetch_unit. Each step pushes
//             the expected post-edge state to a queue; after the edge the
//             entry is popped and compared with the registered outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        hand;
    logic [31:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] nextPC;
  logic        jump_D;
  logic        eret_D;
  logic [31:0] EPC;
  logic        req;
  logic [31:0] PC_F;
  logic        kill_F;
  logic        excValid_F;
  logic [4:0]  ExcCode_F;
  logic        BD_F;
  logic        in_handler;
  logic [31:0] fetch_count;

  int   vectors;
  int   miscompares;
  exp_t sb[$];

  pc_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .nextPC      (nextPC),
    .jump_D      (jump_D),
    .eret_D      (eret_D),
    .EPC         (EPC),
    .req         (req),
    .PC_F        (PC_F),
    .kill_F      (kill_F),
    .excValid_F  (excValid_F),
    .ExcCode_F   (ExcCode_F),
    .BD_F        (BD_F),
    .in_handler  (in_handler),
    .fetch_count (fetch_count)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts the vector, reports and counts a miscompare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the state expected after the next edge
  task automatic drive(input logic rst_n, input logic stl, input logic [31:0] npc,
                       input logic rq, input logic er, input logic [31:0] epc,
                       input logic [31:0] e_pc, input logic e_hand, input logic [31:0] e_cnt);
    exp_t e;
    reset  = rst_n;
    stall  = stl;
    nextPC = npc;
    req    = rq;
    eret_D = er;
    EPC    = epc;
    e.pc   = e_pc;
    e.hand = e_hand;
    e.cnt  = e_cnt;
    sb.push_back(e);
    #1;
  endtask

  // Take the edge, then pop the expectation and compare the registered outputs
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, PC_F);
    end else begin
      e = sb.pop_front();
      check({tag, "_pc"},   PC_F, e.pc);
      check({tag, "_hand"}, {31'd0, in_handler}, {31'd0, e.hand});
      check({tag, "_cnt"},  fetch_count, e.cnt);
    end
  endtask

  task automatic flags(input string tag, input logic e_exc, input logic [4:0] e_code, input logic e_kill);
    check({tag, "_exc"},  {31'd0, excValid_F}, {31'd0, e_exc});
    check({tag, "_code"}, {27'd0, ExcCode_F},  {27'd0, e_code});
    check({tag, "_kill"}, {31'd0, kill_F},     {31'd0, e_kill});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    jump_D      = 1'b0;

    // Reset
    drive(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0000_3000, 1'b0, 32'd0);
    tick("reset");
    flags("reset", 1'b0, 5'd0, 1'b0);

    // Normal advance
    drive(1'b1, 1'b0, 32'h0000_3004, 1'b0, 1'b0, 32'h0, 32'h0000_3004, 1'b0, 32'd1);
    tick("adv1");
    drive(1'b1, 1'b0, 32'h0000_3008, 1'b0, 1'b0, 32'h0, 32'h0000_3008, 1'b0, 32'd2);
    tick("adv2");

    // Stall for three cycles with a delay-slot branch held in D
    jump_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h0000_3010, 1'b0, 1'b0, 32'h0, 32'h0000_3008, 1'b0, 32'd2);
      check("bd_stall", {31'd0, BD_F}, 32'd1);
      tick("stall");
    end
    jump_D = 1'b0;
    #1;
    check("bd_clear", {31'd0, BD_F}, 32'd0);
    drive(1'b1, 1'b0, 32'h0000_3010, 1'b0, 1'b0, 32'h0, 32'h0000_3010, 1'b0, 32'd3);
    tick("unstall");

    // Exception entry overrides stall, counter frozen
    drive(1'b1, 1'b1, 32'h0000_3014, 1'b1, 1'b0, 32'h0, 32'h0000_4180, 1'b1, 32'd3);
    tick("req_stall");

    // eret back to EPC, killed so not counted
    drive(1'b1, 1'b0, 32'h0000_4184, 1'b0, 1'b1, 32'h0000_3020, 32'h0000_3020, 1'b0, 32'd3);
    flags("eret", 1'b0, 5'd0, 1'b1);
    tick("eret");

    // Misaligned fetch target
    drive(1'b1, 1'b0, 32'h0000_3002, 1'b0, 1'b0, 32'h0, 32'h0000_3002, 1'b0, 32'd4);
    tick("mis");
    flags("mis", 1'b1, 5'd4, 1'b1);

    // Above range; previous fetch was killed so no count
    drive(1'b1, 1'b0, 32'h0000_7000, 1'b0, 1'b0, 32'h0, 32'h0000_7000, 1'b0, 32'd4);
    tick("hi");
    flags("hi", 1'b1, 5'd4, 1'b1);

    // Lower bound is legal
    drive(1'b1, 1'b0, 32'h0000_3000, 1'b0, 1'b0, 32'h0, 32'h0000_3000, 1'b0, 32'd4);
    tick("lo_edge");
    flags("lo_edge", 1'b0, 5'd0, 1'b0);

    // Last aligned word below the upper bound is legal
    drive(1'b1, 1'b0, 32'h0000_6FFC, 1'b0, 1'b0, 32'h0, 32'h0000_6FFC, 1'b0, 32'd5);
    tick("hi_edge");
    flags("hi_edge", 1'b0, 5'd0, 1'b0);

    // Just below range
    drive(1'b1, 1'b0, 32'h0000_2FFC, 1'b0, 1'b0, 32'h0, 32'h0000_2FFC, 1'b0, 32'd6);
    tick("below");
    flags("below", 1'b1, 5'd4, 1'b1);

    // Enter handler
    drive(1'b1, 1'b0, 32'h0000_3000, 1'b1, 1'b0, 32'h0, 32'h0000_4180, 1'b1, 32'd6);
    tick("req2");

    // req and eret together in HANDLER: req wins
    drive(1'b1, 1'b0, 32'h0000_4184, 1'b1, 1'b1, 32'h0000_3020, 32'h0000_4180, 1'b1, 32'd6);
    tick("req_eret");

    // Reset wins over a same-cycle req/eret
    drive(1'b0, 1'b0, 32'h0000_4184, 1'b1, 1'b1, 32'h0000_3020, 32'h0000_3000, 1'b0, 32'd0);
    tick("rst_mid");
    flags("rst_mid_idle", 1'b0, 5'd0, 1'b1);

    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
